dm_arbiter: RTL and testbench

//  - Two-port arbiter and sequencer in front of the single-port data_memory (64 x 16).
//  - Port 0 is the CPU load/store path; port 1 is the loader/debug path.
//  - Serialises one transaction at a time onto rd_dm_en/wr_dm_en/dm_addr/wr_dm_data.
//  - Returns read data and a one-cycle ack to the requester that owns the transaction.

---
 rtl/dm_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data_memory.
// Define DM_ARB_RR_EN for round-robin ties; otherwise port 0 wins ties.
module dm_arbiter #(
  parameter int AW     = 6,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          rd_dm_en,
  output logic          wr_dm_en,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] wr_dm_data,
  input  logic [DW-1:0] rd_dm_data,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  localparam logic [1:0] LAT_M1 =
    2'(RD_LAT > 0 ? RD_LAT - 1 : 0);

  state_t        state, state_nx;
  logic [1:0]    cnt, cnt_nx;
  logic          we_q, we_nx;
  logic          win;
  logic          any_req;
  logic          rd_en_nx, wr_en_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] wdata_nx;
  logic          ack0_nx, ack1_nx;
  logic [DW-1:0] rdata0_nx, rdata1_nx;
  logic          gid_nx;
  logic          busy_nx;

  assign any_req = m0_req | m1_req;

`ifdef DM_ARB_RR_EN
  // pref names the port that wins the next tie
  logic pref, pref_nx;

  assign win = (m0_req & m1_req) ? pref : ~m0_req;
  assign pref_nx =
    (state == IDLE && any_req) ? ~win : pref;

  always_ff @(posedge clk) begin
    if (rst) pref <= 1'b0;
    else     pref <= pref_nx;
  end
`else
  assign win = ~m0_req;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    we_nx     = we_q;
    addr_nx   = dm_addr;
    wdata_nx  = wr_dm_data;
    gid_nx    = grant_id;
    rd_en_nx  = 1'b0;
    wr_en_nx  = 1'b0;
    ack0_nx   = 1'b0;
    ack1_nx   = 1'b0;
    rdata0_nx = m0_rdata;
    rdata1_nx = m1_rdata;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          gid_nx   = win;
          we_nx    = win ? m1_we : m0_we;
          addr_nx  = win ? m1_addr : m0_addr;
          wdata_nx = win ? m1_wdata : m0_wdata;
          rd_en_nx = ~we_nx;
          wr_en_nx = we_nx;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          ack0_nx  = ~grant_id;
          ack1_nx  = grant_id;
          state_nx = ACK;
        end else if (RD_LAT == 0) begin
          if (grant_id) rdata1_nx = rd_dm_data;
          else          rdata0_nx = rd_dm_data;
          ack0_nx  = ~grant_id;
          ack1_nx  = grant_id;
          state_nx = ACK;
        end else begin
          cnt_nx   = LAT_M1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          if (grant_id) rdata1_nx = rd_dm_data;
          else          rdata0_nx = rd_dm_data;
          ack0_nx  = ~grant_id;
          ack1_nx  = grant_id;
          state_nx = ACK;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      dm_addr    <= '0;
      wr_dm_data <= '0;
      grant_id   <= 1'b0;
      rd_dm_en   <= 1'b0;
      wr_dm_en   <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      we_q       <= we_nx;
      dm_addr    <= addr_nx;
      wr_dm_data <= wdata_nx;
      grant_id   <= gid_nx;
      rd_dm_en   <= rd_en_nx;
      wr_dm_en   <= wr_en_nx;
      m0_ack     <= ack0_nx;
      m1_ack     <= ack1_nx;
      m0_rdata   <= rdata0_nx;
      m1_rdata   <= rdata1_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: RD_LAT=1 main instance plus an RD_LAT=2 instance.
// Grant-order expectations follow DM_ARB_RR_EN.
module tb_dm_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, preload;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m0_req, m0_we, m0_ack;
  logic [5:0]  m0_addr;
  logic [15:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [5:0]  m1_addr;
  logic [15:0] m1_wdata, m1_rdata;
  logic        rd_dm_en, wr_dm_en, busy, grant_id;
  logic [5:0]  dm_addr;
  logic [15:0] wr_dm_data, rd_dm_data;

  logic        n1_req, n0_ack, n1_ack;
  logic [5:0]  n1_addr;
  logic [15:0] n0_rdata, n1_rdata;
  logic        e_rd, e_wr, e_busy, e_gid;
  logic [5:0]  e_addr;
  logic [15:0] e_wdata, e_rdata;

  dm_arbiter #(.AW(6), .DW(16), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .rd_dm_en(rd_dm_en), .wr_dm_en(wr_dm_en), .dm_addr(dm_addr),
    .wr_dm_data(wr_dm_data), .rd_dm_data(rd_dm_data),
    .busy(busy), .grant_id(grant_id)
  );

  dm_arbiter #(.AW(6), .DW(16), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .m0_req(1'b0), .m0_we(1'b0), .m0_addr(6'd0),
    .m0_wdata(16'd0), .m0_ack(n0_ack), .m0_rdata(n0_rdata),
    .m1_req(n1_req), .m1_we(1'b0), .m1_addr(n1_addr),
    .m1_wdata(16'd0), .m1_ack(n1_ack), .m1_rdata(n1_rdata),
    .rd_dm_en(e_rd), .wr_dm_en(e_wr), .dm_addr(e_addr),
    .wr_dm_data(e_wdata), .rd_dm_data(e_rdata),
    .busy(e_busy), .grant_id(e_gid)
  );

  // memory models: 1-stage and 2-stage registered read
  logic [15:0] mem [64];
  logic [15:0] rq;
  always @(posedge clk) begin
    if (preload) mem[1] <= 16'd222;
    else if (wr_dm_en) mem[dm_addr] <= wr_dm_data;
    if (rd_dm_en) rq <= mem[dm_addr];
  end
  assign rd_dm_data = rq;

  logic [15:0] mem2 [64];
  logic [15:0] rq2a, rq2b;
  always @(posedge clk) begin
    if (preload) mem2[7] <= 16'd3000;
    if (e_rd) rq2a <= mem2[e_addr];
    rq2b <= rq2a;
  end
  assign e_rdata = rq2b;

  typedef struct packed {
    logic [15:0] rdata;
    logic [3:0]  lat;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  int    gseq[$];
  int    tests = 0, fails = 0;
  int    rise_cyc = 0, nack = 0, nack1 = 0;
  int    wr_pulses = 0, ovl = 0;
  int    ack_cyc [2];
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  bit    busy_d = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic mon_pop(input bit p, input logic [15:0] rd);
    item_t it;
    nack++;
    if (p) nack1++;
    ack_cyc[p] = cyc;
    if ((p && q1.size() == 0) || (!p && q0.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL unexpected_ack: port %0d got ack want none", p);
      return;
    end
    if (p) it = q1.pop_front();
    else   it = q0.pop_front();
    check(p ? "m1_rdata" : "m0_rdata", rd, it.rdata);
    check("ack_latency", cyc - rise_cyc, it.lat - 1);
  endtask

  always @(negedge clk) begin
    if (rd_dm_en && wr_dm_en) ovl++;
    if (wr_dm_en) begin
      wr_pulses++;
      wr_addr = dm_addr;
      wr_data = wr_dm_data;
    end
    if (busy && !busy_d) begin
      rise_cyc = cyc;
      gseq.push_back(int'(grant_id));
    end
    busy_d = busy;
    if (m0_ack) mon_pop(1'b0, m0_rdata);
    if (m1_ack) mon_pop(1'b1, m1_rdata);
  end

  task automatic wait_ack(input bit p, output bit got);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = p ? m1_ack : m0_ack;
    end
    check(p ? "m1_ack_seen" : "m0_ack_seen", 32'(got), 1);
  endtask

  task automatic do_req(input bit p, input bit we,
                        input logic [5:0] a, input logic [15:0] d,
                        input logic [15:0] er);
    item_t it;
    bit    got;
    it.rdata = er;
    it.lat   = we ? 4'd2 : 4'd3;
    if (p) begin
      q1.push_back(it);
      m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
    end else begin
      q0.push_back(it);
      m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
    end
    wait_ack(p, got);
    @(posedge clk);
    #1;
    if (p) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, b1, gs, k, a, c;
    bit  got;
    item_t it;
    int  exp_g [4];
    rst = 1'b1; preload = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    n1_req = 0; n1_addr = 0;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_en", {rd_dm_en, wr_dm_en}, 0);
    check("rst_ack", {m0_ack, m1_ack}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    check("rst_addr", 32'(dm_addr), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // write 5 = 1000, then read it back on port 0
    wr_pulses = 0;
    do_req(1'b0, 1'b1, 6'd5, 16'd1000, 16'd0);
    check("wr_pulses", wr_pulses, 1);
    check("wr_addr", 32'(wr_addr), 5);
    check("wr_data", 32'(wr_data), 1000);
    do_req(1'b0, 1'b0, 6'd5, 16'd0, 16'd1000);

    // reset while the read sits in WAIT
    m0_we = 0; m0_addr = 6'd5; m0_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1; m0_req = 1'b0;
    n = nack;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_en", {rd_dm_en, wr_dm_en}, 0);
    check("rst_mid_ack", {m0_ack, m1_ack}, 0);
    check("rst_mid_rdata", 32'(m0_rdata), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("rst_no_ack", nack, n);

    // simultaneous: m0 read 1, m1 write 8 = 4000
    fork
      do_req(1'b0, 1'b0, 6'd1, 16'd0, 16'd222);
      do_req(1'b1, 1'b1, 6'd8, 16'd4000, 16'd0);
    join
    check("tie_order_m0_first", 32'(ack_cyc[0] < ack_cyc[1]), 1);
    do_req(1'b0, 1'b0, 6'd8, 16'd0, 16'd4000);

    // both ports hold req for four transactions
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    b1 = nack1; gs = gseq.size();
    it.lat = 4'd3;
`ifdef DM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
    for (int i = 0; i < 2; i++) begin
      it.rdata = 16'd222;  q0.push_back(it);
      it.rdata = 16'd4000; q1.push_back(it);
    end
`else
    exp_g = '{0, 0, 0, 0};
    it.rdata = 16'd222;
    for (int i = 0; i < 4; i++) q0.push_back(it);
`endif
    m0_we = 0; m0_addr = 6'd1; m1_we = 0; m1_addr = 6'd8;
    m0_req = 1'b1; m1_req = 1'b1;
    k = 0;
    for (int i = 0; i < 100 && k < 4; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) k++;
    end
    check("rr_acks", k, 4);
    @(posedge clk);
    #1 m0_req = 1'b0; m1_req = 1'b0;
    for (int i = 0; i < 4; i++)
      check("grant_seq", (gseq.size() > gs + i) ? gseq[gs + i] : -1, exp_g[i]);
`ifdef DM_ARB_RR_EN
    check("rr_m1_acks", nack1 - b1, 2);
`else
    check("fixed_m1_acks", nack1 - b1, 0);
`endif
    repeat (2) @(posedge clk);
    #1;

    // back-to-back on port 1 with a new address
    it.lat = 4'd3;
    it.rdata = 16'd4000; q1.push_back(it);
    it.rdata = 16'd1000; q1.push_back(it);
    m1_we = 0; m1_addr = 6'd8; m1_req = 1'b1;
    wait_ack(1'b1, got);
    a = cyc;
    @(posedge clk);
    #1 m1_addr = 6'd5;
    wait_ack(1'b1, got);
    check("b2b_issue_cyc", rise_cyc, a + 2);
    @(posedge clk);
    #1 m1_req = 1'b0;

    // RD_LAT = 2 instance, port 1 reads addr 7
    k = cyc;
    n1_addr = 6'd7; n1_req = 1'b1;
    got = 1'b0;
    c = -1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = n1_ack;
      if (got) c = cyc;
    end
    check("lat2_ack_cyc", c, k + 4);
    check("lat2_m1_rdata", 32'(n1_rdata), 3000);
    check("lat2_m0_rdata", 32'(n0_rdata), 0);
    check("lat2_m0_ack", 32'(n0_ack), 0);
    @(posedge clk);
    #1 n1_req = 1'b0;
    repeat (3) @(posedge clk);

    check("en_overlap", ovl, 0);
    check("q_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
